// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_pkg
// Description : Shared types and constants for the RC4 datapath stages
//               (S-memory initialiser, key scheduler, PRGA/decrypt).
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

   // Depth of the S permutation memory
   localparam int S_DEPTH            = 256;
   // Width of one key byte / one S entry
   localparam int KEY_BYTE_W         = 8;
   // Key length in bytes shared by the KSA and PRGA stages
   localparam int DEFAULT_KEY_LENGTH = 3;

   // Key-scheduling controller states, one-hot encoded
   typedef enum logic [9:0] {
      KSA_IDLE    = 10'b00_0000_0001,
      KSA_READ_I  = 10'b00_0000_0010,
      KSA_WAIT_I  = 10'b00_0000_0100,
      KSA_LATCH_I = 10'b00_0000_1000,
      KSA_READ_J  = 10'b00_0001_0000,
      KSA_WAIT_J  = 10'b00_0010_0000,
      KSA_LATCH_J = 10'b00_0100_0000,
      KSA_WRITE_I = 10'b00_1000_0000,
      KSA_WRITE_J = 10'b01_0000_0000,
      KSA_DONE    = 10'b10_0000_0000
   } ksa_state_t;

   // Width of a counter that walks the key bytes 0..key_length-1
   function automatic int key_idx_width(input int key_length);
      return (key_length > 1) ? $clog2(key_length) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_key_byte_sel.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_byte_sel
// Description : Combinational selector returning key byte k of secret_key,
//               byte 0 being the most significant byte.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_byte_sel
   import rc4_pkg::*;
#(
   parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH,
   parameter int KEY_WIDTH  = KEY_BYTE_W * KEY_LENGTH,
   parameter int IDX_W      = key_idx_width(KEY_LENGTH)
) (
   input  logic [KEY_WIDTH-1:0]  secret_key,
   input  logic [IDX_W-1:0]      key_idx,
   output logic [KEY_BYTE_W-1:0] key_byte
);

   // Priority-free mux: exactly one index matches; out-of-range indices give 0
   always_comb begin
      key_byte = '0;
      for (int k = 0; k < KEY_LENGTH; k++) begin
         if (key_idx == IDX_W'(k)) begin
            key_byte = secret_key[KEY_WIDTH-1-KEY_BYTE_W*k -: KEY_BYTE_W];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rc4_ksa_scramble.sv
`default_nettype none
// ============================================================================
// Module      : rc4_ksa_scramble
// Description : RC4 key-scheduling loop over a 256x8 single-port S memory.
//               For i = 0..255: j += S[i] + key[i mod KEY_LENGTH]; swap
//               S[i], S[j]. Eight cycles per iteration; done is sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_ksa_scramble
   import rc4_pkg::*;
#(
   parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH,
   parameter int KEY_WIDTH  = 24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] secret_key,
   input  logic [7:0]           s_q,
   output logic [7:0]           s_address,
   output logic [7:0]           s_data,
   output logic                 s_wren,
   output logic                 done
);

   localparam int                  c_KIDX_W    = key_idx_width(KEY_LENGTH);
   localparam logic [7:0]          c_LAST_I    = 8'(S_DEPTH - 1);
   localparam logic [c_KIDX_W-1:0] c_LAST_KIDX = c_KIDX_W'(KEY_LENGTH - 1);

   ksa_state_t              r_state;
   logic [7:0]              r_i;
   logic [7:0]              r_j;
   logic [7:0]              r_si;
   logic [7:0]              r_sj;
   logic [c_KIDX_W-1:0]     r_key_idx;
   logic [7:0]              r_address;
   logic [7:0]              r_data;
   logic                    r_wren;
   logic                    r_done;

   logic [KEY_BYTE_W-1:0]   w_key_byte;
   logic [7:0]              w_j_next;
   logic [7:0]              w_i_next;

   rc4_key_byte_sel #(
      .KEY_LENGTH (KEY_LENGTH),
      .KEY_WIDTH  (KEY_WIDTH),
      .IDX_W      (c_KIDX_W)
   ) u_key_byte_sel (
      .secret_key (secret_key),
      .key_idx    (r_key_idx),
      .key_byte   (w_key_byte)
   );

   // 8-bit sums wrap naturally; no carry out is kept
   assign w_j_next = r_j + s_q + w_key_byte;
   assign w_i_next = r_i + 8'd1;

   assign s_address = r_address;
   assign s_data    = r_data;
   assign s_wren    = r_wren;
   assign done      = r_done;

   // Controller: outputs are registered alongside the state they belong to,
   // so each state's memory-port values appear for exactly its own cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= KSA_IDLE;
         r_i       <= '0;
         r_j       <= '0;
         r_si      <= '0;
         r_sj      <= '0;
         r_key_idx <= '0;
         r_address <= '0;
         r_data    <= '0;
         r_wren    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            KSA_IDLE: begin
               r_address <= '0;
               r_data    <= '0;
               r_wren    <= 1'b0;
               if (start) begin
                  r_state   <= KSA_READ_I;
                  r_address <= r_i;
               end
            end
            // Address i has been presented; give the RAM its second cycle
            KSA_READ_I: begin
               r_state <= KSA_WAIT_I;
            end
            KSA_WAIT_I: begin
               r_state <= KSA_LATCH_I;
            end
            KSA_LATCH_I: begin
               r_si      <= s_q;
               r_j       <= w_j_next;
               r_address <= w_j_next;
               r_state   <= KSA_READ_J;
            end
            KSA_READ_J: begin
               r_state <= KSA_WAIT_J;
            end
            KSA_WAIT_J: begin
               r_state <= KSA_LATCH_J;
            end
            // S[j] arrives; the first swap write S[i] <= S[j] follows directly
            KSA_LATCH_J: begin
               r_sj      <= s_q;
               r_address <= r_i;
               r_data    <= s_q;
               r_wren    <= 1'b1;
               r_state   <= KSA_WRITE_I;
            end
            KSA_WRITE_I: begin
               r_address <= r_j;
               r_data    <= r_si;
               r_wren    <= 1'b1;
               r_state   <= KSA_WRITE_J;
            end
            KSA_WRITE_J: begin
               r_data <= '0;
               r_wren <= 1'b0;
               if (r_i == c_LAST_I) begin
                  r_address <= '0;
                  r_done    <= 1'b1;
                  r_state   <= KSA_DONE;
               end else begin
                  r_i       <= w_i_next;
                  r_address <= w_i_next;
                  r_key_idx <= (r_key_idx == c_LAST_KIDX) ? '0 : r_key_idx + 1'b1;
                  r_state   <= KSA_READ_I;
               end
            end
            KSA_DONE: begin
               r_wren  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= KSA_DONE;
            end
            default: begin
               r_state   <= KSA_IDLE;
               r_address <= '0;
               r_data    <= '0;
               r_wren    <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa_scramble.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_ksa_scramble
// Description : Self-checking bench for rc4_ksa_scramble with a behavioural
//               single-port S RAM and a software KSA model feeding a
//               write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_ksa_scramble;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [23:0] secret_key = '0;
   logic [7:0]  s_q = '0;
   logic [7:0]  s_address;
   logic [7:0]  s_data;
   logic        s_wren;
   logic        done;

   logic [7:0]  mem [256];
   logic        mem_init = 1'b0;
   logic [7:0]  model_s [256];
   wr_t         exp_q [$];
   wr_t         mon_e;
   int          wr_count = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   rc4_ksa_scramble #(
      .KEY_LENGTH (3),
      .KEY_WIDTH  (24)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .secret_key (secret_key),
      .s_q        (s_q),
      .s_address  (s_address),
      .s_data     (s_data),
      .s_wren     (s_wren),
      .done       (done)
   );

   // Single-port synchronous S RAM
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (s_wren) begin
         mem[s_address] <= s_data;
      end
      s_q <= mem[s_address];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Scoreboard: every write pulse must match the next modelled write
   always @(negedge clk) begin
      if (s_wren) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", {24'd0, s_address}, {24'd0, mon_e.addr});
            check("wr_data", {24'd0, s_data}, {24'd0, mon_e.data});
         end
      end
   end

   // Software KSA on identity S, pushing the expected write sequence
   task automatic model_run(input logic [23:0] key);
      logic [7:0] j, t, kb;
      j = 8'd0;
      for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
      for (int i = 0; i < 256; i++) begin
         kb = 8'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
         j  = j + model_s[i] + kb;
         exp_q.push_back({8'(i), model_s[j]});
         exp_q.push_back({j, model_s[i]});
         t          = model_s[i];
         model_s[i] = model_s[j];
         model_s[j] = t;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      start    = 1'b0;
      reset_n  = 1'b0;
      mem_init = 1'b1;
      @(posedge clk); #1;
      mem_init = 1'b0;
      @(posedge clk); #1;
      reset_n  = 1'b1;
      wr_count = 0;
      exp_q.delete();
   endtask

   task automatic run_ksa(input logic [23:0] key, input string tag, input bit drop_start);
      int n;
      secret_key = key;
      model_run(key);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      n = 1;
      check({tag, "_first_addr"}, {24'd0, s_address}, 32'd0);
      check({tag, "_first_wren"}, {31'd0, s_wren}, 32'd0);
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (drop_start && n == 100) start = 1'b0;
      end
      check({tag, "_done_cycle"}, n, 32'd2049);
      check({tag, "_wr_count"}, wr_count, 32'd512);
      check({tag, "_queue_left"}, exp_q.size(), 32'd0);
      start = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check({tag, "_done_sticky"}, {31'd0, done}, 32'd1);
      check({tag, "_no_more_wr"}, wr_count, 32'd512);
      start = 1'b0;
      for (int k = 0; k < 256; k++)
         check($sformatf("%s_s%0d", tag, k), {24'd0, mem[k]}, {24'd0, model_s[k]});
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  found;
      do_reset();
      check("rst_addr", {24'd0, s_address}, 32'd0);
      check("rst_data", {24'd0, s_data}, 32'd0);
      check("rst_wren", {31'd0, s_wren}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      run_ksa(24'h000000, "k000000", 1'b0);
      do_reset();
      run_ksa(24'h000001, "k000001", 1'b0);
      do_reset();
      run_ksa(24'hFFFFFF, "kffffff", 1'b0);
      do_reset();
      run_ksa(24'h0001C3, "k0001c3", 1'b1);

      // Reset asserted during WRITE_I of iteration 100
      do_reset();
      secret_key = 24'h0001C3;
      model_run(24'h0001C3);
      @(negedge clk);
      start = 1'b1;
      n = 0;
      found = 1'b0;
      while (!found && n < 4000) begin
         @(posedge clk); #1;
         n++;
         if (s_wren && wr_count == 200) found = 1'b1;
      end
      check("mid_found_write_i", {31'd0, found}, 32'd1);
      reset_n = 1'b0;
      start   = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_addr", {24'd0, s_address}, 32'd0);
      check("mid_rst_data", {24'd0, s_data}, 32'd0);
      check("mid_rst_wren", {31'd0, s_wren}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_idle_wren", {31'd0, s_wren}, 32'd0);
      check("mid_idle_addr", {24'd0, s_address}, 32'd0);

      do_reset();
      run_ksa(24'h0001C3, "rerun", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
